gbt_tx_packetizer: RTL and testbench
====================================

// Module: gbt_tx_packetizer
// PURPOSE
//  Parametrised GBT transmit-side framer. Merges NCH channel word streams (valid/ready)
//  into one registered GBT_TXD word stream and drives the GBT_TXVD data-valid strobe.
//  Packets are HDR, payload words, TRL; IDLE words with GBT_TXVD=0 are sent between packets.
//  With EN=0 the block stays in IDLE and holds GBT_TXVD low.
// PARAMETERS
//  NCH       4    number of input channels (1..16)
//  DW        16   payload word width per channel
//  MAX_LEN   64   max payload words per packet (>=1); packet closes at CH_LAST or MAX_LEN
//  STALL_MAX 255  consecutive FILL cycles allowed before forced error close
// PORTS
//  CLK        in   1          single clock domain (all logic)
//  RST_N      in   1          asynchronous, active-low reset
//  EN         in   1          enable packet generation
//  CH_DATA    in   NCH*DW     channel words, ch i at [i*DW +: DW]
//  CH_VALID   in   NCH        per-channel word valid
//  CH_LAST    in   NCH        per-channel last word of packet, qualified by CH_VALID
//  CH_READY   out  NCH        per-channel accept; word transfers when VALID&READY
//  GBT_TXD    out  DW+8       {type[3:0], chan[3:0], data[DW-1:0]}
//  GBT_TXVD   out  1          GBT TX data-valid
//  PKT_CNT    out  16         packets sent (wraps 0xFFFF->0)
//  ERR_CNT    out  8          stall-aborted packets (saturates at 0xFF)
// BEHAVIOUR
//  Reset, async on RST_N low: state IDLE; GBT_TXD={IDLE,0,0}; GBT_TXVD=0; CH_READY=0;
//   PKT_CNT=0; ERR_CNT=0; RR pointer=0. No state survives reset, including mid-packet.
//  Type codes: IDLE=0x0, HDR=0x5, DATA=0xA, FILL=0xC, TRL=0x3, TRL_ERR=0xE.
//  FSM, all outputs registered:
//   IDLE: output IDLE word, TXVD=0. If EN and any CH_VALID: grant the RR winner, starting
//    search at ptr; ptr<=winner+1 mod NCH. Go to HDR.
//   HDR: output {HDR,grant,PKT_CNT[DW-1:0] zero-extended}, TXVD=1. Go to PAYLOAD.
//   PAYLOAD: CH_READY[grant]=1, from registered state only; no VALID->READY comb path.
//    Transfer: next cycle output {DATA,grant,word}, TXVD=1, len++, xor^=word, stall=0.
//    No valid: output {FILL,grant,0}, TXVD=1, stall++.
//    Transfer with CH_LAST or len==MAX_LEN-1: go to TRL; READY drops the following cycle.
//    stall==STALL_MAX with no transfer: go to TRL with error flag set.
//   TRL: output {TRL or TRL_ERR,grant,xor}, TXVD=1. PKT_CNT++ on every TRL.
//    ERR_CNT++ only on TRL_ERR. Clear len/xor/stall. Go to IDLE.
//  Minimum gap: at least one IDLE word between packets.
//  Back-to-back packets on the same channel are allowed when it wins RR again.
//  Latency: accepted word appears on GBT_TXD exactly 1 cycle after the transfer edge.
//  EN falling mid-packet: the current packet completes normally; no new grant while EN=0.
//  Non-granted channels never see READY. CH_LAST with CH_VALID=0 is ignored.
//  Simultaneous CH_LAST and len==MAX_LEN-1: a single close, no duplicate TRL.
//  Empty packets cannot occur except a stall abort, which gives len=0 and TRL_ERR with xor=0.
//  len counter width: clog2(MAX_LEN+1). stall counter width: clog2(STALL_MAX+1).
// STRUCTURE
//  Shared include gbt_tx_defs.vh holds the type-code localparams and the GBT_TXD field
//  offsets (TYPE_LSB=DW+4, CHAN_LSB=DW).
//  One sub-module, gbt_rr_arbiter #(N): inputs req[N], ptr; outputs grant_idx and any_req.
//  Purely combinational. The caller holds the registered ptr.
//  Top level: FSM, counters, XOR accumulator, output registers.
//  The OBUF on GBT_TXVD stays in the board-level wrapper.
// TESTING
//  1 Reset/EN=0: RST_N low mid-PAYLOAD -> GBT_TXVD=0, GBT_TXD=0, CH_READY=0 at once.
//    Release with EN=0 and CH_VALID=0xF -> IDLE held 100 cycles.
//  2 Single packet: EN=1, ch2 sends 0x1234, 0x00FF(LAST) -> HDR(chan2,0000), DATA 1234,
//    DATA 00FF, TRL data 0x12CB; PKT_CNT=1, TXVD high exactly 4 cycles.
//  3 Round robin: all 4 channels valid, 1-word packets -> grant order 0,1,2,3,0.
//    Each packet is separated by one IDLE word.
//  4 MAX_LEN=4, ch1 streams 10 words with no LAST -> packets of 4, 4, 2 data words.
//    Final close needs LAST on word 10. HDR seq values 0, 1, 2.
//  5 Stall: STALL_MAX=3, ch0 sends 1 word then drops VALID -> DATA, 3 FILL, TRL_ERR;
//    ERR_CNT=1. With ERR_CNT at 0xFF, a further abort leaves it at 0xFF.
//  6 EN drop: EN=0 in the middle of a 6-word packet -> packet completes with TRL; no new HDR
//    while EN=0, even with CH_VALID asserted.

Source files
------------

// File: rtl/gbt_tx_packetizer_pkg.sv
// Shared definitions for the GBT transmit packetizer.
//  - GBT_TXD type codes (upper nibble of the transmitted word)
//  - FSM state encoding
//  - idx_w(): index width that never collapses to zero bits
package gbt_tx_packetizer_pkg;

  localparam logic [3:0] TY_IDLE    = 4'h0;
  localparam logic [3:0] TY_HDR     = 4'h5;
  localparam logic [3:0] TY_DATA    = 4'hA;
  localparam logic [3:0] TY_FILL    = 4'hC;
  localparam logic [3:0] TY_TRL     = 4'h3;
  localparam logic [3:0] TY_TRL_ERR = 4'hE;

  // Each state names what happens on the coming edge:
  //  S_IDLE : IDLE word on the line, may grant and load HDR
  //  S_PAY  : HDR/DATA/FILL on the line, READY high, accepting words
  //  S_TRL  : last DATA on the line, emit TRL next
  //  S_END  : TRL/TRL_ERR on the line, force one IDLE word next
  typedef enum logic [1:0] {S_IDLE, S_PAY, S_TRL, S_END} state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gbt_rr_arbiter.sv
// Combinational round-robin picker.
//  req       : request vector
//  ptr       : registered search start (held by the caller)
//  grant_idx : first requester at or after ptr, wrapping
//  any_req   : at least one request present
module gbt_rr_arbiter
  import gbt_tx_packetizer_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = idx_w(N)
)(
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant_idx,
  output logic          any_req
);

  logic found;
  int   idx;

  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        grant_idx = PW'(idx);
        found     = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/gbt_tx_packetizer.sv
// GBT transmit framer: merges NCH valid/ready channel streams into one
// registered word stream of HDR, DATA/FILL words and TRL, with IDLE words
// (txvd low) between packets.
//  clk, rst_n : clock, async active-low reset
//  en         : allow new packets to start
//  ch_data    : channel words, ch i at [i*DW +: DW]
//  ch_valid   : per-channel word valid
//  ch_last    : per-channel end of packet, qualified by ch_valid
//  ch_ready   : per-channel accept (only the granted channel, registered)
//  gbt_txd    : {type[3:0], chan[3:0], data[DW-1:0]}
//  gbt_txvd   : data-valid strobe
//  pkt_cnt    : packets closed (wraps)
//  err_cnt    : stall-aborted packets (saturates)
module gbt_tx_packetizer
  import gbt_tx_packetizer_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DW        = 16,
  parameter int MAX_LEN   = 64,
  parameter int STALL_MAX = 255
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [NCH-1:0]    ch_valid,
  input  logic [NCH-1:0]    ch_last,
  output logic [NCH-1:0]    ch_ready,
  output logic [DW+7:0]     gbt_txd,
  output logic              gbt_txvd,
  output logic [15:0]       pkt_cnt,
  output logic [7:0]        err_cnt
);

  localparam int GW = idx_w(NCH);
  localparam int LW = idx_w(MAX_LEN + 1);
  localparam int SW = idx_w(STALL_MAX + 1);

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d, ptr_q, ptr_d, win;
  logic [LW-1:0]   len_q, len_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [DW-1:0]   xor_q, xor_d, sel_data;
  logic [DW+7:0]   txd_q, txd_d;
  logic            txvd_q, txvd_d, any_req, xfer, sel_last;
  logic [NCH-1:0]  ready_q, ready_d;
  logic [15:0]     pkt_q, pkt_d;
  logic [7:0]      errc_q, errc_d;
  logic [3:0]      chan;

  gbt_rr_arbiter #(.N(NCH)) u_arb (
    .req       (ch_valid),
    .ptr       (ptr_q),
    .grant_idx (win),
    .any_req   (any_req)
  );

  assign chan     = 4'(grant_q);
  assign sel_data = ch_data[int'(grant_q)*DW +: DW];
  assign sel_last = ch_last[grant_q];
  // ready_q is only non-zero in S_PAY, so this is the whole transfer condition
  assign xfer     = ready_q[grant_q] & ch_valid[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    stall_d = stall_q;
    xor_d   = xor_q;
    txd_d   = txd_q;
    txvd_d  = txvd_q;
    ready_d = ready_q;
    pkt_d   = pkt_q;
    errc_d  = errc_q;
    case (state_q)
      S_IDLE: begin
        txd_d  = {TY_IDLE, 4'h0, {DW{1'b0}}};
        txvd_d = 1'b0;
        if (en && any_req) begin
          grant_d      = win;
          ptr_d        = GW'((int'(win) + 1) % NCH);
          ready_d      = '0;
          ready_d[win] = 1'b1;
          txd_d        = {TY_HDR, 4'(win), DW'(pkt_q)};
          txvd_d       = 1'b1;
          state_d      = S_PAY;
        end
      end
      S_PAY: begin
        if (xfer) begin
          txd_d   = {TY_DATA, chan, sel_data};
          len_d   = len_q + LW'(1);
          xor_d   = xor_q ^ sel_data;
          stall_d = '0;
          // LAST and the length limit share one exit, so they cannot double-close
          if (sel_last || len_q == LW'(MAX_LEN - 1)) begin
            ready_d = '0;
            state_d = S_TRL;
          end
        end else if (stall_q == SW'(STALL_MAX)) begin
          // abort: the error trailer replaces the next FILL directly
          txd_d   = {TY_TRL_ERR, chan, xor_q};
          ready_d = '0;
          pkt_d   = pkt_q + 16'd1;
          if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
          len_d   = '0;
          xor_d   = '0;
          stall_d = '0;
          state_d = S_END;
        end else begin
          txd_d   = {TY_FILL, chan, {DW{1'b0}}};
          stall_d = stall_q + SW'(1);
        end
      end
      S_TRL: begin
        txd_d   = {TY_TRL, chan, xor_q};
        pkt_d   = pkt_q + 16'd1;
        len_d   = '0;
        xor_d   = '0;
        stall_d = '0;
        state_d = S_END;
      end
      S_END: begin
        txd_d   = {TY_IDLE, 4'h0, {DW{1'b0}}};
        txvd_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      stall_q <= '0;
      xor_q   <= '0;
      txd_q   <= '0;
      txvd_q  <= 1'b0;
      ready_q <= '0;
      pkt_q   <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      stall_q <= stall_d;
      xor_q   <= xor_d;
      txd_q   <= txd_d;
      txvd_q  <= txvd_d;
      ready_q <= ready_d;
      pkt_q   <= pkt_d;
      errc_q  <= errc_d;
    end
  end

  assign gbt_txd  = txd_q;
  assign gbt_txvd = txvd_q;
  assign ch_ready = ready_q;
  assign pkt_cnt  = pkt_q;
  assign err_cnt  = errc_q;

endmodule

// File: tb/tb_gbt_tx_packetizer.sv
// Directed bench for gbt_tx_packetizer. Two instances share all inputs:
// dut_a (MAX_LEN=4, STALL_MAX=3) and dut_b (MAX_LEN=64, STALL_MAX=3).
// Each test resets both and observes one of them through sel_a.
module tb_gbt_tx_packetizer;
  localparam int NCH = 4;
  localparam int DW  = 16;
  typedef logic [DW+8:0] tw_t;   // {txvd, type, chan, data}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [NCH*DW-1:0] ch_data = '0;
  logic [NCH-1:0] ch_valid = '0, ch_last = '0;
  logic [NCH-1:0] a_ready, b_ready;
  logic [DW+7:0]  a_txd, b_txd;
  logic           a_txvd, b_txvd;
  logic [15:0]    a_pkt, b_pkt;
  logic [7:0]     a_err, b_err;

  always #5 clk = ~clk;

  gbt_tx_packetizer #(.NCH(NCH), .DW(DW), .MAX_LEN(4), .STALL_MAX(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_last(ch_last), .ch_ready(a_ready), .gbt_txd(a_txd), .gbt_txvd(a_txvd),
    .pkt_cnt(a_pkt), .err_cnt(a_err));

  gbt_tx_packetizer #(.NCH(NCH), .DW(DW), .MAX_LEN(64), .STALL_MAX(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_last(ch_last), .ch_ready(b_ready), .gbt_txd(b_txd), .gbt_txvd(b_txvd),
    .pkt_cnt(b_pkt), .err_cnt(b_err));

  int passed = 0;
  int total  = 0;
  bit sel_a  = 1'b0;
  tw_t trace[$];
  logic [NCH-1:0] rdy_q[$];

  always @(negedge clk) begin
    trace.push_back(sel_a ? {a_txvd, a_txd} : {b_txvd, b_txd});
    rdy_q.push_back(sel_a ? a_ready : b_ready);
  end

  function automatic tw_t wd(input logic vd, input logic [3:0] ty,
                             input logic [3:0] ch, input logic [15:0] d);
    return {vd, ty, ch, d};
  endfunction

  function automatic int first_vd();
    for (int i = 0; i < trace.size(); i++)
      if (trace[i][DW+8] === 1'b1) return i;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; ch_valid = '0; ch_last = '0; ch_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    trace.delete();
    rdy_q.delete();
  endtask

  task automatic put(input int ch, input logic [15:0] d, input logic l);
    ch_data[ch*DW +: DW] = d;
    ch_last[ch]  = l;
    ch_valid[ch] = 1'b1;
  endtask

  // Streams n words base, base+step, ... on one channel, reacting to ready.
  // Returns at the negedge where the last word is on the line.
  task automatic send_words(input int ch, input int n, input logic [15:0] base,
                            input logic [15:0] step, input bit last_end,
                            input int drop_en_after, output bit ok);
    int idx;
    bit pend;
    logic [NCH-1:0] rdy;
    idx = 0; pend = 1'b0; ok = 1'b0;
    put(ch, base, last_end && n == 1);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (pend) begin
        idx++;
        if (idx == drop_en_after) en = 1'b0;
        if (idx >= n) begin
          ch_valid[ch] = 1'b0; ch_last[ch] = 1'b0; ok = 1'b1;
          break;
        end
        put(ch, base + 16'(idx) * step, last_end && idx == n - 1);
      end
      rdy  = sel_a ? a_ready : b_ready;
      pend = rdy[ch] && ch_valid[ch];
    end
  endtask

  // Grants ch0 then withdraws it before any transfer: empty packet, stall abort.
  task automatic abort_empty(output bit ok, output logic [15:0] xr);
    bit got;
    ok = 1'b0; xr = 'x; got = 1'b0;
    ch_valid[0] = 1'b1; ch_last[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (a_txvd === 1'b1 && a_txd[23:20] === 4'h5) begin got = 1'b1; break; end
    end
    ch_valid[0] = 1'b0;
    if (got) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (a_txd[23:20] === 4'hE) begin ok = 1'b1; xr = a_txd[15:0]; break; end
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    sel_a = 1'b0;
    do_reset();
    en = 1'b1;
    put(2, 16'h5555, 1'b0);
    repeat (4) @(negedge clk);
    total++; if (b_txvd !== 1'b1 || b_ready !== 4'b0100)
      $display("FAIL reset_pre: txvd=%b ready=%b want 1/0100", b_txvd, b_ready); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (b_txvd !== 1'b0) $display("FAIL reset_txvd: got %b want 0", b_txvd); else passed++;
    total++; if (b_txd !== 24'h0) $display("FAIL reset_txd: got %h want 000000", b_txd); else passed++;
    total++; if (b_ready !== 4'h0) $display("FAIL reset_ready: got %b want 0000", b_ready); else passed++;
    total++; if (b_pkt !== 16'h0 || b_err !== 8'h0)
      $display("FAIL reset_cnt: pkt=%h err=%h want 0/0", b_pkt, b_err); else passed++;
    ch_valid = 4'hF; ch_last = '0; en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (b_txvd !== 1'b0 || b_txd !== 24'h0 || b_ready !== 4'h0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL en0_idle: %0d non-idle cycles, want 0", bad); else passed++;
  endtask

  task automatic test_single();
    tw_t exp[$];
    int s, nv, nr, stray;
    bit ok;
    sel_a = 1'b0;
    do_reset();
    en = 1'b1;
    // step chosen so the second word is 0x00FF
    send_words(2, 2, 16'h1234, 16'hEECB, 1'b1, -1, ok);
    total++; if (ok !== 1'b1) $display("FAIL single_send: timeout"); else passed++;
    repeat (3) @(negedge clk);
    exp = '{wd(1, 4'h5, 4'd2, 16'h0000), wd(1, 4'hA, 4'd2, 16'h1234),
            wd(1, 4'hA, 4'd2, 16'h00FF), wd(1, 4'h3, 4'd2, 16'h12CB),
            wd(0, 4'h0, 4'd0, 16'h0000)};
    s = first_vd();
    for (int k = 0; k < exp.size(); k++) begin
      tw_t act;
      act = (s >= 0 && s + k < trace.size()) ? trace[s+k] : 'x;
      total++; if (act !== exp[k])
        $display("FAIL single_word[%0d]: got %h want %h", k, act, exp[k]); else passed++;
    end
    nv = 0; nr = 0; stray = 0;
    for (int i = 0; i < trace.size(); i++) begin
      if (trace[i][DW+8] === 1'b1) nv++;
      if (rdy_q[i][2] === 1'b1) nr++;
      if ((rdy_q[i] & 4'b1011) !== 4'b0) stray++;
    end
    total++; if (nv !== 4) $display("FAIL single_txvd_cycles: got %0d want 4", nv); else passed++;
    total++; if (nr !== 2) $display("FAIL single_ready_cycles: got %0d want 2", nr); else passed++;
    total++; if (stray !== 0) $display("FAIL single_stray_ready: got %0d want 0", stray); else passed++;
    total++; if (b_pkt !== 16'd1) $display("FAIL single_pkt_cnt: got %0d want 1", b_pkt); else passed++;
  endtask

  task automatic test_round_robin();
    tw_t exp[$];
    int s;
    sel_a = 1'b0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < NCH; i++) put(i, 16'h00A0 + 16'(i), 1'b1);
    repeat (22) @(negedge clk);
    ch_valid = '0; ch_last = '0;
    for (int p = 0; p < 5; p++) begin
      logic [3:0] c;
      c = 4'(p % 4);
      exp.push_back(wd(1, 4'h5, c, 16'(p)));
      exp.push_back(wd(1, 4'hA, c, 16'h00A0 + 16'(c)));
      exp.push_back(wd(1, 4'h3, c, 16'h00A0 + 16'(c)));
      exp.push_back(wd(0, 4'h0, 4'h0, 16'h0000));
    end
    s = first_vd();
    for (int k = 0; k < exp.size(); k++) begin
      tw_t act;
      act = (s >= 0 && s + k < trace.size()) ? trace[s+k] : 'x;
      total++; if (act !== exp[k])
        $display("FAIL rr_word[%0d]: got %h want %h", k, act, exp[k]); else passed++;
    end
  endtask

  task automatic test_max_len();
    tw_t exp[$];
    int s, w;
    bit ok;
    sel_a = 1'b1;
    do_reset();
    en = 1'b1;
    send_words(1, 10, 16'h1F00, 16'h0123, 1'b1, -1, ok);
    total++; if (ok !== 1'b1) $display("FAIL maxlen_send: timeout"); else passed++;
    repeat (3) @(negedge clk);
    w = 0;
    for (int p = 0; p < 3; p++) begin
      logic [15:0] x;
      x = '0;
      exp.push_back(wd(1, 4'h5, 4'd1, 16'(p)));
      for (int k = 0; k < ((p < 2) ? 4 : 2); k++) begin
        logic [15:0] d;
        d = 16'h1F00 + 16'(w) * 16'h0123;
        exp.push_back(wd(1, 4'hA, 4'd1, d));
        x ^= d;
        w++;
      end
      exp.push_back(wd(1, 4'h3, 4'd1, x));
      exp.push_back(wd(0, 4'h0, 4'h0, 16'h0000));
    end
    s = first_vd();
    for (int k = 0; k < exp.size(); k++) begin
      tw_t act;
      act = (s >= 0 && s + k < trace.size()) ? trace[s+k] : 'x;
      total++; if (act !== exp[k])
        $display("FAIL maxlen_word[%0d]: got %h want %h", k, act, exp[k]); else passed++;
    end
    total++; if (a_pkt !== 16'd3) $display("FAIL maxlen_pkt_cnt: got %0d want 3", a_pkt); else passed++;
  endtask

  task automatic test_stall();
    tw_t exp[$];
    int s, npk;
    bit ok;
    logic [15:0] xr;
    sel_a = 1'b1;
    do_reset();
    en = 1'b1;
    send_words(0, 1, 16'hBEEF, 16'h0000, 1'b0, -1, ok);
    total++; if (ok !== 1'b1) $display("FAIL stall_send: timeout"); else passed++;
    repeat (6) @(negedge clk);
    exp = '{wd(1, 4'h5, 4'd0, 16'h0000), wd(1, 4'hA, 4'd0, 16'hBEEF),
            wd(1, 4'hC, 4'd0, 16'h0000), wd(1, 4'hC, 4'd0, 16'h0000),
            wd(1, 4'hC, 4'd0, 16'h0000), wd(1, 4'hE, 4'd0, 16'hBEEF),
            wd(0, 4'h0, 4'd0, 16'h0000)};
    s = first_vd();
    for (int k = 0; k < exp.size(); k++) begin
      tw_t act;
      act = (s >= 0 && s + k < trace.size()) ? trace[s+k] : 'x;
      total++; if (act !== exp[k])
        $display("FAIL stall_word[%0d]: got %h want %h", k, act, exp[k]); else passed++;
    end
    total++; if (a_err !== 8'd1) $display("FAIL stall_err_cnt: got %0d want 1", a_err); else passed++;
    npk = 1;
    abort_empty(ok, xr);
    npk++;
    total++; if (ok !== 1'b1 || xr !== 16'h0000)
      $display("FAIL empty_abort_xor: ok=%b xor=%h want 1/0000", ok, xr); else passed++;
    for (int n = 0; n < 300 && a_err !== 8'hFF; n++) begin
      abort_empty(ok, xr);
      npk++;
      if (!ok) break;
    end
    total++; if (a_err !== 8'hFF) $display("FAIL err_reach_ff: got %h want ff", a_err); else passed++;
    abort_empty(ok, xr);
    npk++;
    total++; if (ok !== 1'b1 || a_err !== 8'hFF)
      $display("FAIL err_saturate: ok=%b err=%h want 1/ff", ok, a_err); else passed++;
    total++; if (a_pkt !== 16'(npk)) $display("FAIL abort_pkt_cnt: got %0d want %0d", a_pkt, npk); else passed++;
  endtask

  task automatic test_en_drop();
    tw_t exp[$];
    int s, nv;
    bit ok, got;
    logic [15:0] x;
    sel_a = 1'b0;
    do_reset();
    en = 1'b1;
    send_words(3, 6, 16'h3000, 16'h0111, 1'b1, 3, ok);
    total++; if (ok !== 1'b1) $display("FAIL endrop_send: timeout"); else passed++;
    for (int i = 0; i < NCH; i++) put(i, 16'h7700 + 16'(i), 1'b1);
    repeat (25) @(negedge clk);
    x = '0;
    exp.push_back(wd(1, 4'h5, 4'd3, 16'h0000));
    for (int k = 0; k < 6; k++) begin
      exp.push_back(wd(1, 4'hA, 4'd3, 16'h3000 + 16'(k) * 16'h0111));
      x ^= 16'h3000 + 16'(k) * 16'h0111;
    end
    exp.push_back(wd(1, 4'h3, 4'd3, x));
    exp.push_back(wd(0, 4'h0, 4'h0, 16'h0000));
    s = first_vd();
    for (int k = 0; k < exp.size(); k++) begin
      tw_t act;
      act = (s >= 0 && s + k < trace.size()) ? trace[s+k] : 'x;
      total++; if (act !== exp[k])
        $display("FAIL endrop_word[%0d]: got %h want %h", k, act, exp[k]); else passed++;
    end
    nv = 0;
    for (int i = 0; i < trace.size(); i++) if (trace[i][DW+8] === 1'b1) nv++;
    total++; if (nv !== 8) $display("FAIL endrop_no_new_hdr: txvd cycles %0d want 8", nv); else passed++;
    total++; if (b_pkt !== 16'd1) $display("FAIL endrop_pkt_cnt: got %0d want 1", b_pkt); else passed++;
    en = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b_txvd === 1'b1) begin got = 1'b1; break; end
    end
    total++; if (!got || {b_txvd, b_txd} !== wd(1, 4'h5, 4'd0, 16'h0001))
      $display("FAIL reenable_hdr: got %b/%h want 1/500001", b_txvd, b_txd); else passed++;
    ch_valid = '0; ch_last = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_max_len();
    test_stall();
    test_en_drop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
